// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//   Decode-side hazard scoreboard placed directly upstream of the register
//   file read ports. It records which architectural registers have a write
//   in flight. It stalls issue on RAW/WAW hazards or when too many writes
//   are outstanding. It releases a register when writeback presents the
//   write to the register file.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   id_vld       decode has an instruction to issue
//   id_p0_addr   source 0 register        id_re0  source 0 used
//   id_p1_addr   source 1 register        id_re1  source 1 used
//   id_dst_addr  destination register     id_we   instruction writes a reg
//   id_rdy       issue accepted this cycle (combinational)
//   wb_we        writeback writes the register file this cycle
//   wb_dst_addr  writeback destination register
//   flush        squash: clear all tracking
//   pending      registered pending-write bit per register (bit 0 always 0)
//   outstanding  registered number of in-flight writes (0..MAX_OUT)
//   stall_cnt    saturating count of stalled cycles
//   wb_err       sticky flag: writeback to a register that was not pending
// ---------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int MAX_OUT  = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_vld,
    input  logic [ADDR_W-1:0]   id_p0_addr,
    input  logic [ADDR_W-1:0]   id_p1_addr,
    input  logic                id_re0,
    input  logic                id_re1,
    input  logic [ADDR_W-1:0]   id_dst_addr,
    input  logic                id_we,
    output logic                id_rdy,
    input  logic                wb_we,
    input  logic [ADDR_W-1:0]   wb_dst_addr,
    input  logic                flush,
    output logic [NUM_REGS-1:0] pending,
    output logic [2:0]          outstanding,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic                wb_err
);

    localparam logic [ADDR_W-1:0]   ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [NUM_REGS-1:0] ONE_HOT0  = {{(NUM_REGS-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [2:0]          OUT_LIMIT = 3'(MAX_OUT);

    logic                wb_clr_s;
    logic                wb_bad_s;
    logic                raw0_s;
    logic                raw1_s;
    logic                waw_s;
    logic                full_s;
    logic                rdy_s;
    logic                acc_s;
    logic                set_s;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] clr_mask_s;

    // Hazard detection, issue acceptance and the set/clear masks.
    always_comb begin
        wb_clr_s = wb_we && (wb_dst_addr != ZERO_ADDR) && pending[wb_dst_addr];
        wb_bad_s = wb_we && (wb_dst_addr != ZERO_ADDR) && !pending[wb_dst_addr] && !flush;

        // A register released by writeback this cycle is bypassed: the RF
        // writes in the high phase and reads in the low phase.
        raw0_s = id_re0 && (id_p0_addr != ZERO_ADDR) && pending[id_p0_addr]
                 && !(wb_clr_s && (wb_dst_addr == id_p0_addr));
        raw1_s = id_re1 && (id_p1_addr != ZERO_ADDR) && pending[id_p1_addr]
                 && !(wb_clr_s && (wb_dst_addr == id_p1_addr));
        waw_s  = id_we && (id_dst_addr != ZERO_ADDR) && pending[id_dst_addr]
                 && !(wb_clr_s && (wb_dst_addr == id_dst_addr));
        // A slot freed by writeback this cycle can be reused immediately.
        full_s = (outstanding == OUT_LIMIT) && !wb_clr_s;

        rdy_s  = !raw0_s && !raw1_s && !waw_s && !full_s && !flush;
        acc_s  = id_vld && rdy_s;
        set_s  = acc_s && id_we && (id_dst_addr != ZERO_ADDR);

        if (set_s) begin
            set_mask_s = ONE_HOT0 << id_dst_addr;
        end else begin
            set_mask_s = {NUM_REGS{1'b0}};
        end

        if (wb_clr_s) begin
            clr_mask_s = ONE_HOT0 << wb_dst_addr;
        end else begin
            clr_mask_s = {NUM_REGS{1'b0}};
        end
    end

    assign id_rdy = rdy_s;

    // Pending bitmap and in-flight counter; set is applied after clear so a
    // same-cycle set/clear of one register leaves it pending.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pending     <= {NUM_REGS{1'b0}};
            outstanding <= 3'd0;
        end else begin
            pending     <= (pending & ~clr_mask_s) | set_mask_s;
            outstanding <= outstanding + {2'b00, set_s} - {2'b00, wb_clr_s};
        end
    end

    // Saturating stall counter; flush cycles with a waiting instruction count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= {CNT_W{1'b0}};
        end else if (id_vld && !rdy_s && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

    // Sticky writeback-error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_err <= 1'b0;
        end else if (wb_bad_s) begin
            wb_err <= 1'b1;
        end else begin
            wb_err <= wb_err;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
//   Drives directed scenarios and randomized traffic into reg_scoreboard.
//   The stimulus process updates a register-level reference model and pushes
//   the outputs expected during each cycle into a queue; a monitor process
//   pops one entry per cycle and compares it with what the DUT shows.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;

    typedef struct packed {
        logic       rst;
        logic       vld;
        logic       re0;
        logic       re1;
        logic       we;
        logic       wb_we;
        logic       flush;
        logic [3:0] p0;
        logic [3:0] p1;
        logic [3:0] dst;
        logic [3:0] wd;
    } stim_t;

    typedef struct packed {
        logic        rdy;
        logic [15:0] pend;
        logic [2:0]  outst;
        logic [15:0] stall;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, id_vld, id_re0, id_re1, id_we, wb_we, flush;
    logic [3:0]  id_p0_addr, id_p1_addr, id_dst_addr, wb_dst_addr;
    logic        id_rdy, wb_err;
    logic [15:0] pending, stall_cnt;
    logic [2:0]  outstanding;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Reference model state: one flag per register, stall count, error flag.
    bit  m_pend[16];
    int  m_stall;
    bit  m_err;
    bit  m_rdy;

    reg_scoreboard dut (
        .clk(clk), .rst(rst), .id_vld(id_vld),
        .id_p0_addr(id_p0_addr), .id_p1_addr(id_p1_addr),
        .id_re0(id_re0), .id_re1(id_re1),
        .id_dst_addr(id_dst_addr), .id_we(id_we), .id_rdy(id_rdy),
        .wb_we(wb_we), .wb_dst_addr(wb_dst_addr), .flush(flush),
        .pending(pending), .outstanding(outstanding),
        .stall_cnt(stall_cnt), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    function automatic int m_count();
        int n = 0;
        for (int r = 0; r < 16; r++) if (m_pend[r]) n++;
        return n;
    endfunction

    // A register blocks an access if it has a write in flight that this
    // cycle's writeback is not handing to the register file.
    function automatic bit m_busy(logic [3:0] r, logic release_wb, logic [3:0] wd);
        if (r == 4'd0) return 1'b0;
        if (!m_pend[r]) return 1'b0;
        if (release_wb && wd == r) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step(input stim_t s, input bit chk);
        exp_t e;
        bit   release_wb;
        @(posedge clk);
        #2;
        rst = s.rst; id_vld = s.vld; id_re0 = s.re0; id_re1 = s.re1;
        id_we = s.we; wb_we = s.wb_we; flush = s.flush;
        id_p0_addr = s.p0; id_p1_addr = s.p1; id_dst_addr = s.dst;
        wb_dst_addr = s.wd;

        release_wb = s.wb_we && s.wd != 4'd0 && m_pend[s.wd];
        m_rdy = !(s.re0 && m_busy(s.p0, release_wb, s.wd))
             && !(s.re1 && m_busy(s.p1, release_wb, s.wd))
             && !(s.we  && m_busy(s.dst, release_wb, s.wd))
             && !(m_count() == 4 && !release_wb)
             && !s.flush;

        e.rdy   = m_rdy;
        e.outst = 3'(m_count());
        e.stall = 16'(m_stall);
        e.err   = m_err;
        for (int r = 0; r < 16; r++) e.pend[r] = m_pend[r];
        if (chk) exp_q.push_back(e);

        // Advance the model to the state after this clock edge.
        if (s.rst) begin
            for (int r = 0; r < 16; r++) m_pend[r] = 1'b0;
            m_stall = 0;
            m_err   = 1'b0;
        end else begin
            if (s.vld && !m_rdy && m_stall < 65535) m_stall++;
            if (s.wb_we && s.wd != 4'd0 && !m_pend[s.wd] && !s.flush) m_err = 1'b1;
            if (s.flush) begin
                for (int r = 0; r < 16; r++) m_pend[r] = 1'b0;
            end else begin
                if (release_wb) m_pend[s.wd] = 1'b0;
                if (s.vld && m_rdy && s.we && s.dst != 4'd0) m_pend[s.dst] = 1'b1;
            end
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: compares one expected entry per cycle in the clock-low phase.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("id_rdy",      32'(id_rdy),      32'(e.rdy));
            cmp("pending",     32'(pending),     32'(e.pend));
            cmp("outstanding", 32'(outstanding), 32'(e.outst));
            cmp("stall_cnt",   32'(stall_cnt),   32'(e.stall));
            cmp("wb_err",      32'(wb_err),      32'(e.err));
        end
    end

    function automatic stim_t idle();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t issue(logic [3:0] dst);
        stim_t s = '0;
        s.vld = 1'b1; s.we = 1'b1; s.dst = dst;
        return s;
    endfunction

    initial begin
        stim_t s, prev;
        bit    prev_stalled;
        int    cand[$];

        rst = 1'b1; id_vld = 1'b0; id_re0 = 1'b0; id_re1 = 1'b0; id_we = 1'b0;
        wb_we = 1'b0; flush = 1'b0; id_p0_addr = 4'd0; id_p1_addr = 4'd0;
        id_dst_addr = 4'd0; wb_dst_addr = 4'd0;
        m_stall = 0; m_err = 1'b0;
        for (int r = 0; r < 16; r++) m_pend[r] = 1'b0;

        // Reset
        s = idle(); s.rst = 1'b1;
        step(s, 1'b0);
        step(s, 1'b1);

        // Issue R3, then a reader of R3 stalls 3 cycles, then writeback frees it
        step(issue(4'd3), 1'b1);
        s = idle(); s.vld = 1'b1; s.re0 = 1'b1; s.p0 = 4'd3;
        repeat (3) step(s, 1'b1);
        s.wb_we = 1'b1; s.wd = 4'd3;
        step(s, 1'b1);
        step(idle(), 1'b1);

        // Same-cycle release and re-issue of R5; issue to R0
        step(issue(4'd5), 1'b1);
        s = issue(4'd5); s.wb_we = 1'b1; s.wd = 4'd5;
        step(s, 1'b1);
        step(issue(4'd0), 1'b1);
        s = idle(); s.wb_we = 1'b1; s.wd = 4'd5;
        step(s, 1'b1);

        // Fill to MAX_OUT, fifth issue waits for a free slot
        step(issue(4'd1), 1'b1);
        step(issue(4'd2), 1'b1);
        step(issue(4'd4), 1'b1);
        step(issue(4'd6), 1'b1);
        repeat (2) step(issue(4'd7), 1'b1);
        s = issue(4'd7); s.wb_we = 1'b1; s.wd = 4'd4;
        step(s, 1'b1);
        step(idle(), 1'b1);

        // Flush with pending registers, then a stray writeback sets wb_err
        s = idle(); s.rst = 1'b1;
        step(s, 1'b1);
        step(issue(4'd2), 1'b1);
        step(issue(4'd9), 1'b1);
        s = issue(4'd8); s.flush = 1'b1;
        step(s, 1'b1);
        s = idle(); s.wb_we = 1'b1; s.wd = 4'd9;
        step(s, 1'b1);
        repeat (3) step(idle(), 1'b1);

        // Randomized traffic respecting the hold-while-stalled rule
        s = idle(); s.rst = 1'b1;
        step(s, 1'b1);
        prev = idle(); prev_stalled = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            s = idle();
            if (prev_stalled) begin
                s.vld = prev.vld; s.re0 = prev.re0; s.re1 = prev.re1; s.we = prev.we;
                s.p0 = prev.p0; s.p1 = prev.p1; s.dst = prev.dst;
            end else begin
                s.vld = ($urandom_range(0, 3) != 0);
                s.re0 = $urandom_range(0, 1); s.re1 = $urandom_range(0, 1);
                s.we  = ($urandom_range(0, 3) != 0);
                s.p0  = 4'($urandom_range(0, 15)); s.p1 = 4'($urandom_range(0, 15));
                s.dst = 4'($urandom_range(0, 15));
            end
            cand.delete();
            for (int r = 1; r < 16; r++) if (m_pend[r]) cand.push_back(r);
            if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
                s.wb_we = 1'b1;
                s.wd = 4'(cand[$urandom_range(0, cand.size() - 1)]);
            end else if ($urandom_range(0, 19) == 0) begin
                s.wb_we = 1'b1;
                s.wd = 4'($urandom_range(0, 15));
            end
            s.flush = ($urandom_range(0, 49) == 0);
            s.rst   = ($urandom_range(0, 199) == 0);
            step(s, 1'b1);
            prev = s;
            prev_stalled = s.vld && !m_rdy && !s.rst;
        end

        // Saturate the stall counter using a held flush, then reset mid-stall
        s = idle(); s.rst = 1'b1;
        step(s, 1'b1);
        s = idle(); s.vld = 1'b1; s.flush = 1'b1;
        repeat (65540) step(s, 1'b1);
        s.rst = 1'b1;
        step(s, 1'b1);
        step(idle(), 1'b1);
        step(idle(), 1'b1);

        @(negedge clk);
        @(negedge clk);
        cmp("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
